// File: rtl/lfsr8_debruijn_checker_if.sv
// lfsr8_debruijn_checker_if: checker bus; master drives din_valid/din/clear, slave drives locked/err/err_cnt
interface lfsr8_debruijn_checker_if;
  logic        din_valid;
  logic [7:0]  din;
  logic        clear;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  modport master(output din_valid, din, clear, input locked, err, err_cnt);
  modport slave(input din_valid, din, clear, output locked, err, err_cnt);
endinterface

// File: rtl/lfsr8_debruijn_checker.sv
// lfsr8_debruijn_checker: self-syncing checker for the 8-bit XNOR de Bruijn sequence; clk, reset (async high), bus: din_valid/din/clear in, locked/err/err_cnt out
module lfsr8_debruijn_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8
) (
  input logic clk,
  input logic reset,
  lfsr8_debruijn_checker_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state;
  logic [7:0] prev, expected;
  logic [3:0] match_cnt, miss_cnt, match_inc, miss_inc;
  logic fb, hit, miss;
  always_comb begin
    fb = prev[7] ^ (&prev[6:0]);
    expected = {prev[6:4], ~(fb ^ prev[3]), ~(fb ^ prev[2]), ~(fb ^ prev[1]), prev[0], fb};
    hit = bus.din == expected;
    miss = bus.din_valid && state == LOCKED && !hit;
    match_inc = match_cnt + 4'd1;
    miss_inc = miss_cnt + 4'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      prev <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      bus.err <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      bus.err <= miss;
      if (bus.clear) bus.err_cnt <= '0;
      else if (miss && bus.err_cnt != 16'hFFFF) bus.err_cnt <= bus.err_cnt + 16'd1;
      if (bus.din_valid) begin
        if (state == HUNT) begin
          prev <= bus.din;
          match_cnt <= hit ? match_inc : 4'd0;
          if (hit && match_inc == 4'(LOCK_CNT)) begin
            state <= LOCKED;
            match_cnt <= '0;
            miss_cnt <= '0;
          end
        end else if (hit) begin
          prev <= expected;
          miss_cnt <= '0;
        end else if (miss_inc == 4'(LOSS_CNT)) begin
          state <= HUNT;
          prev <= bus.din;
          match_cnt <= '0;
          miss_cnt <= '0;
        end else begin
          prev <= expected;
          miss_cnt <= miss_inc;
        end
      end
    end
  end
  assign bus.locked = state == LOCKED;
endmodule

// File: tb/tb_lfsr8_debruijn_checker.sv
// tb_lfsr8_debruijn_checker: randomized-gap stimulus checked every cycle against a table-driven sequence model
module tb_lfsr8_debruijn_checker;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  lfsr8_debruijn_checker_if bus();
  lfsr8_debruijn_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int gap_mode = 0;
  int g = 0;
  logic [7:0] seq [256];
  int pos [256];
  logic [7:0] last_bad = 8'h00;
  bit m_locked = 1'b0;
  bit m_err = 1'b0;
  logic [7:0] m_last = 8'h00;
  int m_phase = 0;
  int m_run = 0;
  int m_bad = 0;
  int m_cnt = 0;
  function automatic logic [7:0] step(input logic [7:0] x);
    logic f;
    f = x[7] ^ (&x[6:0]);
    return {x[6:4], ~(f ^ x[3]), ~(f ^ x[2]), ~(f ^ x[1]), x[0], f};
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_locked = 1'b0;
      m_last = 8'h00;
      m_run = 0;
      m_bad = 0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      m_err = 1'b0;
      if (bus.din_valid) begin
        if (!m_locked) begin
          m_run = (bus.din == seq[(pos[m_last] + 1) % 256]) ? m_run + 1 : 0;
          m_last = bus.din;
          if (m_run == LOCK_CNT) begin
            m_locked = 1'b1;
            m_phase = pos[m_last];
            m_run = 0;
            m_bad = 0;
          end
        end else begin
          m_phase = (m_phase + 1) % 256;
          if (bus.din == seq[m_phase]) m_bad = 0;
          else begin
            m_err = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            m_bad++;
            if (m_bad == LOSS_CNT) begin
              m_locked = 1'b0;
              m_last = bus.din;
              m_run = 0;
              m_bad = 0;
            end
          end
        end
      end
      if (bus.clear) m_cnt = 0;
    end
    #1;
    chk("model_locked", bus.locked, m_locked);
    chk("model_err", bus.err, m_err);
    chk("model_err_cnt", bus.err_cnt, m_cnt);
    if (bus.err) pulses++;
  end
  task automatic beat(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    bus.din_valid = v;
    bus.din = d;
    bus.clear = c;
  endtask
  task automatic word(input logic [7:0] d);
    beat(1'b1, d, 1'b0);
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(3) == 0)) beat(1'b0, 8'h00, 1'b0);
  endtask
  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      g = (g + 1) % 256;
      word(seq[g]);
    end
  endtask
  task automatic bad(input int n);
    for (int i = 0; i < n; i++) begin
      g = (g + 1) % 256;
      last_bad = (seq[g] == 8'hA5) ? 8'h5A : 8'hA5;
      word(last_bad);
    end
  endtask
  task automatic idle();
    beat(1'b0, 8'h00, 1'b0);
  endtask
  task automatic clr();
    beat(1'b0, 8'h00, 1'b1);
    beat(1'b0, 8'h00, 1'b0);
  endtask
  initial begin
    int n;
    int p0;
    bit seen [256];
    bus.din_valid = 1'b0;
    bus.din = 8'h00;
    bus.clear = 1'b0;
    seq[0] = 8'h00;
    for (int i = 1; i < 256; i++) seq[i] = step(seq[i-1]);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      if (!seen[seq[i]]) n++;
      seen[seq[i]] = 1'b1;
      pos[seq[i]] = i;
    end
    chk("seq_first", seq[1], 8'h1C);
    chk("seq_second", seq[2], 8'h24);
    chk("seq_wrap", step(seq[255]), 8'h00);
    chk("seq_distinct", n, 256);
    #1;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    good(3);
    idle();
    chk("lock_after_3", bus.locked, 0);
    good(1);
    idle();
    chk("lock_after_4", bus.locked, 1);
    chk("lock_err_cnt", bus.err_cnt, 0);
    gap_mode = 2;
    good(512);
    idle();
    chk("two_periods_pulses", pulses, 0);
    chk("two_periods_locked", bus.locked, 1);
    for (int m = 0; m < 2; m++) begin
      gap_mode = m;
      p0 = pulses;
      g = (g + 1) % 256;
      word(seq[g] ^ 8'h01);
      good(1);
      idle();
      chk("single_err_cnt", bus.err_cnt, 1);
      chk("single_err_pulses", pulses - p0, 1);
      chk("single_err_locked", bus.locked, 1);
      clr();
      chk("clear_err_cnt", bus.err_cnt, 0);
    end
    gap_mode = 0;
    bad(7);
    idle();
    chk("loss_7_locked", bus.locked, 1);
    chk("loss_7_err_cnt", bus.err_cnt, 7);
    bad(1);
    idle();
    chk("loss_8_locked", bus.locked, 0);
    chk("loss_8_err_cnt", bus.err_cnt, 8);
    do g = $urandom_range(255); while (seq[(g + 1) % 256] == step(last_bad));
    gap_mode = 2;
    good(4);
    idle();
    chk("relock_4_words", bus.locked, 0);
    good(1);
    idle();
    chk("relock_5_words", bus.locked, 1);
    chk("relock_err_cnt", bus.err_cnt, 8);
    gap_mode = 0;
    clr();
    for (int k = 0; k < 9362; k++) begin
      bad(7);
      good(1);
    end
    bad(1);
    good(1);
    idle();
    chk("sat_reach", bus.err_cnt, 16'hFFFF);
    chk("sat_locked", bus.locked, 1);
    p0 = pulses;
    bad(3);
    good(1);
    idle();
    chk("sat_hold", bus.err_cnt, 16'hFFFF);
    chk("sat_pulses", pulses - p0, 3);
    g = (g + 1) % 256;
    beat(1'b1, seq[g] ^ 8'h80, 1'b1);
    idle();
    chk("clear_vs_err_err", bus.err, 1);
    chk("clear_vs_err_cnt", bus.err_cnt, 0);
    idle();
    chk("err_one_cycle", bus.err, 0);
    good(2);
    bad(1);
    @(negedge clk);
    chk("pre_reset_err", bus.err, 1);
    chk("pre_reset_cnt", bus.err_cnt, 1);
    bus.din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_locked", bus.locked, 0);
    chk("async_rst_err", bus.err, 0);
    chk("async_rst_cnt", bus.err_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    g = 0;
    good(3);
    idle();
    chk("rehunt_3", bus.locked, 0);
    good(1);
    idle();
    chk("rehunt_4", bus.locked, 1);
    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
